// File: rtl/plane_state_array.sv
// plane_state_array: kinematic state for NUM_PLANES aircraft. One shared
// fixed-point datapath is stepped through every plane on each update_enable
// pulse. It integrates the angles, speed and position of each plane and
// classifies it as flying, landed or crashed. Direction cosines come from an
// external trig unit over a req/ack handshake.
module plane_state_array #(
    parameter int unsigned           NUM_PLANES     = 2,
    parameter int unsigned           FRAC_BITS      = 16,
    parameter logic [31+FRAC_BITS:0] DT             = 48'h00_0000_199A,
    parameter int unsigned           STALL_SPEED    = 20,
    parameter int unsigned           STALL_ACCEL    = 10,
    parameter int unsigned           THRUST_COEF    = 100,
    parameter int unsigned           DRAG_COEF      = 5,
    parameter logic [31+FRAC_BITS:0] MASS_INV       = 48'h00_0000_028F,
    parameter int unsigned           LAND_SPEED_MAX = 40,
    parameter int unsigned           LAND_PITCH_MAX = 10,
    parameter int unsigned           INITIAL_Y      = 1000,
    parameter int unsigned           INITIAL_SPEED  = 100
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   update_enable,
    output logic                                   update_done,
    output logic                                   busy,
    input  logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   pitch_rate,
    input  logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   roll_rate,
    input  logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   heading_rate,
    input  logic [NUM_PLANES*8-1:0]                throttle,
    output logic                                   trig_req,
    output logic [31+FRAC_BITS:0]                  trig_pitch,
    output logic [31+FRAC_BITS:0]                  trig_heading,
    input  logic                                   trig_ack,
    input  logic [31+FRAC_BITS:0]                  dir_x,
    input  logic [31+FRAC_BITS:0]                  dir_y,
    input  logic [31+FRAC_BITS:0]                  dir_z,
    output logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   x,
    output logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   y,
    output logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   z,
    output logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   speed,
    output logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   pitch,
    output logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   roll,
    output logic [NUM_PLANES*(32+FRAC_BITS)-1:0]   heading,
    output logic [NUM_PLANES*3-1:0]                plane_state_bits
);

    localparam int unsigned W  = 32 + FRAC_BITS;
    localparam int unsigned CW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;

    localparam logic signed [W-1:0] FX_360      = W'(360) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_270      = W'(270) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_STALL    = W'(STALL_SPEED) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_ACCEL    = W'(STALL_ACCEL) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_THRUST   = W'(THRUST_COEF) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_DRAG     = W'(DRAG_COEF) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_LAND_SPD = W'(LAND_SPEED_MAX) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_LAND_PLO = W'(LAND_PITCH_MAX) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_LAND_PHI = FX_360 - FX_LAND_PLO;
    localparam logic signed [W-1:0] FX_INIT_Y   = W'(INITIAL_Y) << FRAC_BITS;
    localparam logic signed [W-1:0] FX_INIT_SPD = W'(INITIAL_SPEED) << FRAC_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ANGLE, S_SPEED, S_TRIG, S_POS, S_GROUND, S_DONE
    } state_e;

    typedef enum logic [2:0] {
        FLYING  = 3'b001,
        LANDED  = 3'b010,
        CRASHED = 3'b100
    } pstate_e;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic [W-1:0] speed;
        logic [W-1:0] pitch;
        logic [W-1:0] roll;
        logic [W-1:0] heading;
        pstate_e      st;
    } plane_t;

    // Clamp a double-width intermediate into the signed W range.
    function automatic logic signed [W-1:0] sat2w(input logic signed [2*W-1:0] v);
        if ((&v[2*W-1:W-1]) || !(|v[2*W-1:W-1]))
            sat2w = v[W-1:0];
        else if (v[2*W-1])
            sat2w = {1'b1, {(W-1){1'b0}}};
        else
            sat2w = {1'b0, {(W-1){1'b1}}};
    endfunction

    function automatic logic signed [W-1:0] fx_mul(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        fx_mul = sat2w(p >>> FRAC_BITS);
    endfunction

    function automatic logic signed [W-1:0] fx_add(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
        fx_add = sat2w((2*W)'(a) + (2*W)'(b));
    endfunction

    function automatic logic signed [W-1:0] fx_sub(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
        fx_sub = sat2w((2*W)'(a) - (2*W)'(b));
    endfunction

    // Single +/-360 correction into [0,360).
    function automatic logic signed [W-1:0] wrap360(input logic signed [W-1:0] v);
        if (v >= FX_360)
            wrap360 = v - FX_360;
        else if (v[W-1])
            wrap360 = v + FX_360;
        else
            wrap360 = v;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    plane_t        work_q, work_d;
    plane_t        plane_q [NUM_PLANES];
    plane_t        plane_d [NUM_PLANES];
    logic [W-1:0]  prate_q, prate_d, rrate_q, rrate_d, hrate_q, hrate_d;
    logic [7:0]    thr_q, thr_d;
    logic [W-1:0]  dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;

    logic signed [W-1:0] thr_fx, thrust, drag, net, spd_new;
    logic                last, y_le0;
    plane_t              grd;

    // State, working registers and per-plane committed state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            work_q  <= '0;
            prate_q <= '0;
            rrate_q <= '0;
            hrate_q <= '0;
            thr_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            dz_q    <= '0;
            for (int unsigned i = 0; i < NUM_PLANES; i++)
                plane_q[i] <= '{x: '0, y: FX_INIT_Y, z: '0, speed: FX_INIT_SPD,
                                pitch: '0, roll: '0, heading: '0, st: FLYING};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            work_q  <= work_d;
            prate_q <= prate_d;
            rrate_q <= rrate_d;
            hrate_q <= hrate_d;
            thr_q   <= thr_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            dz_q    <= dz_d;
            plane_q <= plane_d;
        end
    end

    // Next-state sequencing and the shared datapath, one step per state.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        work_d  = work_q;
        prate_d = prate_q;
        rrate_d = rrate_q;
        hrate_d = hrate_q;
        thr_d   = thr_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        dz_d    = dz_q;
        plane_d = plane_q;
        thr_fx  = W'(thr_q) << FRAC_BITS;
        thrust  = '0;
        drag    = '0;
        net     = '0;
        spd_new = '0;
        last    = (ch_q == CW'(NUM_PLANES - 1));
        y_le0   = work_q.y[W-1] || (work_q.y == '0);
        grd     = work_q;

        case (state_q)
            S_IDLE: begin
                if (update_enable) begin
                    state_d = S_LOAD;
                    ch_d    = '0;
                end
            end
            S_LOAD: begin
                work_d  = plane_q[ch_q];
                prate_d = pitch_rate[ch_q*W +: W];
                rrate_d = roll_rate[ch_q*W +: W];
                hrate_d = heading_rate[ch_q*W +: W];
                thr_d   = (throttle[ch_q*8 +: 8] > 8'd100) ? 8'd100 : throttle[ch_q*8 +: 8];
                if (plane_q[ch_q].st == CRASHED) begin
                    if (last)
                        state_d = S_DONE;
                    else
                        ch_d = ch_q + CW'(1);
                end else begin
                    state_d = S_ANGLE;
                end
            end
            S_ANGLE: begin
                work_d.pitch   = wrap360(fx_add(work_q.pitch,   fx_mul(prate_q, DT)));
                work_d.roll    = wrap360(fx_add(work_q.roll,    fx_mul(rrate_q, DT)));
                work_d.heading = wrap360(fx_add(work_q.heading, fx_mul(hrate_q, DT)));
                state_d        = S_SPEED;
            end
            S_SPEED: begin
                if ($signed(work_q.speed) < FX_STALL) begin
                    work_d.pitch = FX_270;
                    work_d.speed = fx_add(work_q.speed, fx_mul(FX_ACCEL, DT));
                end else begin
                    thrust       = fx_mul(FX_THRUST, thr_fx);
                    drag         = fx_mul(fx_mul(FX_DRAG, work_q.speed), work_q.speed);
                    net          = fx_sub(thrust, drag);
                    spd_new      = fx_add(work_q.speed, fx_mul(fx_mul(net, MASS_INV), DT));
                    work_d.speed = spd_new[W-1] ? '0 : spd_new;
                end
                state_d = S_TRIG;
            end
            S_TRIG: begin
                if (trig_ack) begin
                    dx_d    = dir_x;
                    dy_d    = dir_y;
                    dz_d    = dir_z;
                    state_d = S_POS;
                end
            end
            S_POS: begin
                work_d.x = fx_add(work_q.x, fx_mul(fx_mul(work_q.speed, dx_q), DT));
                work_d.y = fx_add(work_q.y, fx_mul(fx_mul(work_q.speed, dy_q), DT));
                work_d.z = fx_add(work_q.z, fx_mul(fx_mul(work_q.speed, dz_q), DT));
                state_d  = S_GROUND;
            end
            S_GROUND: begin
                if (work_q.st == FLYING && y_le0) begin
                    grd.y = '0;
                    if ($signed(work_q.speed) <= FX_LAND_SPD &&
                        ($signed(work_q.pitch) <= FX_LAND_PLO ||
                         $signed(work_q.pitch) >= FX_LAND_PHI))
                        grd.st = LANDED;
                    else
                        grd.st = CRASHED;
                end else if (work_q.st == LANDED) begin
                    if (y_le0)
                        grd.y = '0;
                    else
                        grd.st = FLYING;
                end
                // Whole channel commits at once on the edge leaving GROUND.
                plane_d[ch_q] = grd;
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs and packing of per-plane state onto the flat buses.
    always_comb begin
        busy             = (state_q != S_IDLE);
        update_done      = (state_q == S_DONE);
        trig_req         = (state_q == S_TRIG);
        trig_pitch       = work_q.pitch;
        trig_heading     = work_q.heading;
        x                = '0;
        y                = '0;
        z                = '0;
        speed            = '0;
        pitch            = '0;
        roll             = '0;
        heading          = '0;
        plane_state_bits = '0;
        for (int unsigned i = 0; i < NUM_PLANES; i++) begin
            x[i*W +: W]               = plane_q[i].x;
            y[i*W +: W]               = plane_q[i].y;
            z[i*W +: W]               = plane_q[i].z;
            speed[i*W +: W]           = plane_q[i].speed;
            pitch[i*W +: W]           = plane_q[i].pitch;
            roll[i*W +: W]            = plane_q[i].roll;
            heading[i*W +: W]         = plane_q[i].heading;
            plane_state_bits[i*3 +: 3] = plane_q[i].st;
        end
    end

endmodule
